// File: rtl/fan_pwm_driver_if.sv
// Fan driver signal bundle: mode request and tach in, PWM gate and status out.
interface fan_pwm_driver_if;
  logic [2:0] fan_mode;
  logic       tach;
  logic       fault_clr;
  logic       pwm_out;
  logic [7:0] duty_level;
  logic       fan_on;
  logic       fault;

  // Producer side: cooling FSM / environment
  modport master (
    output fan_mode, tach, fault_clr,
    input  pwm_out, duty_level, fan_on, fault
  );

  // Consumer side: the PWM driver
  modport slave (
    input  fan_mode, tach, fault_clr,
    output pwm_out, duty_level, fan_on, fault
  );
endinterface

// File: rtl/fan_pwm_driver.sv
// Fan PWM driver: maps cooling mode to a duty, kicks the fan from standstill,
// slews between duties and updates only at PWM period boundaries.
// Optional tach stall detection is built when FAN_STALL_DETECT_EN is defined.
module fan_pwm_driver #(
  parameter int unsigned KICK_PERIODS  = 4,
  parameter int unsigned RAMP_STEP     = 16,
  parameter int unsigned RAMP_PERIODS  = 2,
  parameter int unsigned STALL_TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            rst,
  fan_pwm_driver_if.slave bus
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DUTY_W  = 8;
  localparam int unsigned STALL_W = 16;
  localparam int unsigned KICK_W  = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
  localparam int unsigned RAMP_W  = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_KICK = 3'd1,
    S_HOLD = 3'd2,
    S_RAMP = 3'd3
`ifdef FAN_STALL_DETECT_EN
    , S_FAULT = 3'd4
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [KICK_W-1:0]   kick_cnt_q, kick_cnt_d;
  logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
  logic                pwm_q, pwm_d;
  logic                fan_on_q, fan_on_d;

  logic                boundary_c;
  logic [DUTY_W-1:0]   target_c;
  logic [DUTY_W-1:0]   ramp_next_c;
  logic                stall_hit_c;

  // Mode to target duty decode
  always_comb begin
    target_c = DUTY_MAX;
    case (bus.fan_mode)
      3'd0:    target_c = 8'd0;
      3'd1:    target_c = 8'd64;
      3'd2:    target_c = 8'd128;
      3'd3:    target_c = 8'd192;
      default: target_c = DUTY_MAX;
    endcase
  end

  // One slew step toward the target, clamped so it never overshoots
  always_comb begin
    logic [DUTY_W:0] diff;
    ramp_next_c = target_c;
    diff        = '0;
    if (target_c > duty_q) begin
      diff = (DUTY_W+1)'(target_c) - (DUTY_W+1)'(duty_q);
      if (diff > (DUTY_W+1)'(RAMP_STEP)) ramp_next_c = duty_q + DUTY_W'(RAMP_STEP);
    end else begin
      diff = (DUTY_W+1)'(duty_q) - (DUTY_W+1)'(target_c);
      if (diff > (DUTY_W+1)'(RAMP_STEP)) ramp_next_c = duty_q - DUTY_W'(RAMP_STEP);
    end
  end

  assign boundary_c = (cnt_q == CNT_W'(255));

`ifdef FAN_STALL_DETECT_EN
  logic               tach_s1_q, tach_s2_q, tach_prev_q;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               fault_q, fault_d;
  logic               tach_rise_c;
  logic               stall_active_c;
  logic               stall_entry_c;

  // Tach synchroniser and rising-edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tach_s1_q   <= 1'b0;
      tach_s2_q   <= 1'b0;
      tach_prev_q <= 1'b0;
    end else begin
      tach_s1_q   <= bus.tach;
      tach_s2_q   <= tach_s1_q;
      tach_prev_q <= tach_s2_q;
    end
  end

  assign tach_rise_c    = tach_s2_q & ~tach_prev_q;
  assign stall_active_c = ((state_q == S_HOLD) || (state_q == S_RAMP)) && (duty_q != '0);
  assign stall_hit_c    = stall_active_c && (stall_cnt_q == STALL_W'(STALL_TIMEOUT));
  assign stall_entry_c  = ((state_d == S_HOLD) || (state_d == S_RAMP)) && (state_d != state_q);

  // Clocks since the last tach edge while the fan should be spinning
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_entry_c || !stall_active_c || tach_rise_c) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != STALL_W'(STALL_TIMEOUT)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end
`else
  logic unused_stall_inputs;
  assign stall_hit_c         = 1'b0;
  assign unused_stall_inputs = ^{bus.tach, bus.fault_clr, STALL_W'(STALL_TIMEOUT)};
`endif

  // Next state, duty and period bookkeeping
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    kick_cnt_d = kick_cnt_q;
    ramp_cnt_d = ramp_cnt_q;
    cnt_d      = cnt_q + CNT_W'(1);
    pwm_d      = (duty_q == DUTY_MAX) || (cnt_q < duty_q);

    case (state_q)
      S_OFF: begin
        duty_d = '0;
        if (boundary_c && (target_c != '0)) begin
          state_d    = S_KICK;
          duty_d     = DUTY_MAX;
          kick_cnt_d = '0;
        end
      end
      S_KICK: begin
        duty_d = DUTY_MAX;
        if (boundary_c) begin
          if (target_c == '0) begin
            state_d = S_OFF;
            duty_d  = '0;
          end else if (kick_cnt_q == KICK_W'(KICK_PERIODS - 1)) begin
            state_d = S_HOLD;
            duty_d  = target_c;
          end else begin
            kick_cnt_d = kick_cnt_q + KICK_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (boundary_c && (target_c != duty_q)) begin
          state_d    = S_RAMP;
          ramp_cnt_d = '0;
        end
      end
      S_RAMP: begin
        if (boundary_c) begin
          if (duty_q == target_c) begin
            state_d = (target_c == '0) ? S_OFF : S_HOLD;
          end else if (ramp_cnt_q == RAMP_W'(RAMP_PERIODS - 1)) begin
            duty_d     = ramp_next_c;
            ramp_cnt_d = '0;
          end else begin
            ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
          end
        end
      end
`ifdef FAN_STALL_DETECT_EN
      S_FAULT: begin
        duty_d = DUTY_MAX;
        if (bus.fault_clr) begin
          state_d = S_OFF;
          duty_d  = '0;
        end
      end
`endif
      default: begin
        state_d = S_OFF;
        duty_d  = '0;
      end
    endcase

`ifdef FAN_STALL_DETECT_EN
    // A stall overrides any boundary decision taken this cycle
    if (stall_hit_c) begin
      state_d = S_FAULT;
      duty_d  = DUTY_MAX;
    end
    fault_d = (state_d == S_FAULT);
`endif
    fan_on_d = (state_d != S_OFF);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      duty_q     <= '0;
      kick_cnt_q <= '0;
      ramp_cnt_q <= '0;
      pwm_q      <= 1'b0;
      fan_on_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      kick_cnt_q <= kick_cnt_d;
      ramp_cnt_q <= ramp_cnt_d;
      pwm_q      <= pwm_d;
      fan_on_q   <= fan_on_d;
    end
  end

`ifdef FAN_STALL_DETECT_EN
  // Stall counter and latched fault flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fault_q     <= fault_d;
    end
  end
  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.pwm_out    = pwm_q;
  assign bus.duty_level = duty_q;
  assign bus.fan_on     = fan_on_q;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Directed bench for fan_pwm_driver; cycle numbers count clocks since reset release.
module tb_fan_pwm_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  fan_pwm_driver_if bus();

  fan_pwm_driver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  // Hold reset two cycles, release on a falling edge
  task automatic do_reset();
    rst = 1'b1;
    bus.fan_mode  = 3'd0;
    bus.tach      = 1'b0;
    bus.fault_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // Count pwm highs over the next n clocks
  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.pwm_out === 1'b1) hi++;
    end
  endtask

  initial begin
    int hi;
    int bad;

    bus.fan_mode  = 3'd0;
    bus.tach      = 1'b0;
    bus.fault_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pwm", 32'(bus.pwm_out), 32'd0);
    chk("rst_duty", 32'(bus.duty_level), 32'd0);
    chk("rst_fan_on", 32'(bus.fan_on), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    rst = 1'b0;
    cyc = 0;

    // Idle with mode 0
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (bus.pwm_out !== 1'b0 || bus.duty_level !== 8'd0 || bus.fan_on !== 1'b0) bad++;
    end
    chk("idle_outputs_nonzero_count", 32'(bad), 32'd0);

    // Mode 2 mid-period: kick at 2048, hold 128 at 3072
    bus.fan_mode = 3'd2;
    run_to(2047);
    chk("pre_boundary_fan_on", 32'(bus.fan_on), 32'd0);
    run_to(2048);
    chk("kick_fan_on", 32'(bus.fan_on), 32'd1);
    chk("kick_duty", 32'(bus.duty_level), 32'd255);
    count_high(1024, hi);
    chk("kick_pwm_highs", 32'(hi), 32'd1024);
    chk("hold128_duty", 32'(bus.duty_level), 32'd128);
    count_high(256, hi);
    chk("hold128_pwm_highs", 32'(hi), 32'd128);

    // Ramp up 128 -> 192
    run_to(3400);
    bus.fan_mode = 3'd3;
    run_to(4095);
    chk("ramp_up_pre", 32'(bus.duty_level), 32'd128);
    run_to(4096);
    chk("ramp_up_144", 32'(bus.duty_level), 32'd144);
    run_to(4608);
    chk("ramp_up_160", 32'(bus.duty_level), 32'd160);
    run_to(5120);
    chk("ramp_up_176", 32'(bus.duty_level), 32'd176);
    run_to(5632);
    chk("ramp_up_192", 32'(bus.duty_level), 32'd192);
    run_to(6200);
    chk("hold192_duty", 32'(bus.duty_level), 32'd192);
    chk("hold192_fan_on", 32'(bus.fan_on), 32'd1);

    // Ramp down 192 -> 0, then OFF
    bus.fan_mode = 3'd0;
    run_to(6911);
    chk("ramp_dn_pre", 32'(bus.duty_level), 32'd192);
    run_to(6912);
    chk("ramp_dn_176", 32'(bus.duty_level), 32'd176);
    run_to(12543);
    chk("ramp_dn_16", 32'(bus.duty_level), 32'd16);
    run_to(12544);
    chk("ramp_dn_0", 32'(bus.duty_level), 32'd0);
    chk("ramp_dn_0_fan_on", 32'(bus.fan_on), 32'd1);
    run_to(12799);
    chk("pre_off_fan_on", 32'(bus.fan_on), 32'd1);
    run_to(12800);
    chk("off_fan_on", 32'(bus.fan_on), 32'd0);
    chk("off_pwm", 32'(bus.pwm_out), 32'd0);
    chk("off_duty", 32'(bus.duty_level), 32'd0);

    // Mode 6 from OFF: kick then full duty
    run_to(12900);
    bus.fan_mode = 3'd6;
    run_to(13056);
    chk("m6_kick_duty", 32'(bus.duty_level), 32'd255);
    run_to(14080);
    chk("m6_hold_duty", 32'(bus.duty_level), 32'd255);
    count_high(256, hi);
    chk("m6_pwm_highs", 32'(hi), 32'd256);

    // Ramp toward 192, retarget to 64 mid-ramp
    run_to(14400);
    bus.fan_mode = 3'd3;
    run_to(15104);
    chk("rt_239", 32'(bus.duty_level), 32'd239);
    run_to(15616);
    chk("rt_223", 32'(bus.duty_level), 32'd223);
    run_to(15700);
    bus.fan_mode = 3'd1;
    run_to(16640);
    chk("rt_191", 32'(bus.duty_level), 32'd191);
    run_to(20735);
    chk("rt_79", 32'(bus.duty_level), 32'd79);
    run_to(20736);
    chk("rt_clamp_64", 32'(bus.duty_level), 32'd64);
    run_to(21300);
    chk("rt_hold_64", 32'(bus.duty_level), 32'd64);
    count_high(256, hi);
    chk("rt_pwm_highs", 32'(hi), 32'd64);

    // Target drops to 0 during kick
    do_reset();
    bus.fan_mode = 3'd5;
    run_to(256);
    chk("kick0_duty", 32'(bus.duty_level), 32'd255);
    run_to(300);
    bus.fan_mode = 3'd0;
    run_to(511);
    chk("kick0_pre_fan_on", 32'(bus.fan_on), 32'd1);
    run_to(512);
    chk("kick0_fan_on", 32'(bus.fan_on), 32'd0);
    chk("kick0_duty_off", 32'(bus.duty_level), 32'd0);

    // Asynchronous reset mid-kick
    do_reset();
    bus.fan_mode = 3'd4;
    run_to(400);
    chk("mk_fan_on", 32'(bus.fan_on), 32'd1);
    chk("mk_pwm", 32'(bus.pwm_out), 32'd1);
    chk("mk_fault", 32'(bus.fault), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mk_rst_pwm", 32'(bus.pwm_out), 32'd0);
    chk("mk_rst_duty", 32'(bus.duty_level), 32'd0);
    chk("mk_rst_fan_on", 32'(bus.fan_on), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

`ifdef FAN_STALL_DETECT_EN
    // Stall: hold at 128 from 1280, tach low, fault at 5377
    do_reset();
    bus.fan_mode = 3'd2;
    run_to(1280);
    chk("st_hold_duty", 32'(bus.duty_level), 32'd128);
    run_to(5376);
    chk("st_pre_fault", 32'(bus.fault), 32'd0);
    run_to(5377);
    chk("st_fault", 32'(bus.fault), 32'd1);
    chk("st_fault_duty", 32'(bus.duty_level), 32'd255);
    run_to(5400);
    bus.fan_mode = 3'd0;
    count_high(256, hi);
    chk("st_pwm_highs", 32'(hi), 32'd256);
    run_to(6000);
    chk("st_sticky_fault", 32'(bus.fault), 32'd1);
    chk("st_sticky_duty", 32'(bus.duty_level), 32'd255);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("st_clr_fault", 32'(bus.fault), 32'd0);
    chk("st_clr_fan_on", 32'(bus.fan_on), 32'd0);
    chk("st_clr_duty", 32'(bus.duty_level), 32'd0);

    // Tach toggling every 1000 clocks keeps the fan out of fault
    do_reset();
    bus.fan_mode = 3'd2;
    bad = 0;
    for (int i = 1; i <= 12000; i++) begin
      tick();
      if (i % 1000 == 0) bus.tach = ~bus.tach;
      if (bus.fault !== 1'b0) bad++;
    end
    chk("tach_no_fault_count", 32'(bad), 32'd0);
    chk("tach_duty", 32'(bus.duty_level), 32'd128);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
